irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_SRC, default 4, SHALL set the number of interrupt sources, with a legal range of 2..8.
REQ-002 Parameter DB_CYCLES, default 4, SHALL set the number of consecutive stable samples needed to accept a level change, with a legal range of 1..2^20.
REQ-003 Port clk, input, 1 bit: the single clock; every flop SHALL be on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port src_in, input, N_SRC bits: raw asynchronous interrupt lines (board buttons), active-high.
REQ-006 Port mask_wr, input, 1 bit: mask write strobe.
REQ-007 Port mask_din, input, N_SRC bits: new enable mask; 1 = enabled.
REQ-008 Port irq_ack, input, 1 bit: one-cycle pulse from control when it enters the ISR.
REQ-009 Port irq_done, input, 1 bit: one-cycle pulse from control on ISR return.
REQ-010 Port irq, output, 1 bit: registered interrupt request to control.
REQ-011 Port irq_id, output, clog2(N_SRC) bits: registered source index, valid while irq or in_service is high.
REQ-012 Port pending, output, N_SRC bits: registered pending flags.
REQ-013 Port in_service, output, 1 bit: registered flag, high while the ISR is active.

Function
REQ-014 Each src_in bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-015 Each source SHALL have a debounced level db[i] that flips on the edge where sync[i] has differed from db[i] on DB_CYCLES consecutive edges; any sample that matches db[i] SHALL reset that source's counter.
REQ-016 On the edge where db[i] goes 0 to 1, pending[i] SHALL be set; the 1 to 0 transition SHALL have no effect on pending.
REQ-017 A rising edge on a source whose pending bit is already set SHALL leave it set, with no counting.
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, SERVICE.
REQ-019 IDLE to REQ SHALL occur when (pending & mask) != 0; on that edge irq_id SHALL latch the lowest set index of (pending & mask).
REQ-020 irq SHALL be 1 exactly while the state is REQ; in_service SHALL be 1 exactly while the state is SERVICE.
REQ-021 In REQ, irq_ack SHALL cause REQ to SERVICE and clear pending[irq_id] on the same edge.
REQ-022 In REQ, if a mask write clears mask[irq_id] with no irq_ack in that cycle, the state SHALL return to IDLE and irq SHALL drop.
REQ-023 In REQ, if irq_ack and a mask write clearing mask[irq_id] occur in the same cycle, irq_ack SHALL win.
REQ-024 In SERVICE, no new request SHALL be raised (no nesting); irq_done SHALL cause SERVICE to IDLE.
REQ-025 irq_ack outside REQ and irq_done outside SERVICE SHALL be ignored.
REQ-026 If a set event and a clear event hit the same pending bit in one cycle, set SHALL win.
REQ-027 mask_wr SHALL load mask_din on the next edge; mask SHALL NOT alter pending bits.
REQ-028 Latency: with src_in high from before edge 1, pending SHALL rise after edge DB_CYCLES+2 and irq after edge DB_CYCLES+3.
REQ-029 Debounce counters SHALL saturate and SHALL NOT wrap.

Reset
REQ-030 While rst is high, the module SHALL be asynchronously in the following state: state=IDLE, irq=0, irq_id=0, in_service=0, pending=0, mask all ones, db=0, synchronizers=0, counters=0.
REQ-031 A reset asserted mid-service SHALL discard the in-flight request and all pending bits; no request SHALL follow reset release unless a new debounced edge occurs.

Structure
REQ-032 Package cpu_irq_pkg SHALL hold the FSM state type and the N_SRC and ID-width constants.
REQ-033 Sub-module irq_debounce SHALL implement the synchronizer, debounce counter and rise pulse for one source, and SHALL be instantiated N_SRC times.

Verification
REQ-034 Test 1: DB_CYCLES=4, src_in=4'b0100 held -> pending=4'b0100 after edge 6, irq=1 and irq_id=2 after edge 7.
REQ-035 Test 2: src_in[1] glitches high for 3 cycles -> pending stays 0 and irq stays 0.
REQ-036 Test 3: src_in=4'b1010 together -> irq_id=1; after irq_ack then irq_done, second request with irq_id=3.
REQ-037 Test 4: In REQ with irq_id=0, mask_wr with mask_din=4'b1110 and no ack -> irq=0 next cycle, state IDLE, pending[0] stays 1.
REQ-038 Test 5: New edge on src 2 during SERVICE -> pending=4'b0100 but irq=0 until irq_done, then irq=1 two edges later.
REQ-039 Test 6: rst pulsed during SERVICE -> in_service=0, pending=0 and mask=4'b1111 immediately, with no irq after release.

Source files
------------

// File: rtl/cpu_irq_pkg.sv
// cpu_irq_pkg: shared FSM state type and sizing constants for the interrupt controller
// Provides irq_state_e, default source count and ID width, and id_w() to size irq_id.
package cpu_irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_e;
  localparam int DEF_N_SRC = 4;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int DEF_ID_W = id_w(DEF_N_SRC);
endpackage

// File: rtl/irq_debounce.sv
// irq_debounce: 2-flop synchronizer, saturating debounce counter and rise pulse for one line
// Ports: clk, rst (async high), d_i raw line, db_o debounced level, rise_o 0->1 pulse of db_o.
module irq_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic db_o,
  output logic rise_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [1:0] sync_q;
  logic db_q, db_d, diff, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff   = sync_q[1] ^ db_q;
    flip   = diff && (cnt_q >= CW'(DB_CYCLES - 1));
    db_d   = flip ? ~db_q : db_q;
    cnt_d  = (!diff || flip) ? '0 : (cnt_q == CW'(DB_CYCLES)) ? cnt_q : cnt_q + CW'(1);
    rise_o = flip & ~db_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end
  assign db_o = db_q;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: debounced, maskable, non-nesting interrupt controller with lowest-index priority
// Ports: clk, rst (async high), src_in raw lines, mask_wr/mask_din mask write, irq_ack/irq_done
// handshake from control; irq, irq_id, pending, in_service registered status outputs.
module irq_ctrl
  import cpu_irq_pkg::*;
#(
  parameter int N_SRC     = DEF_N_SRC,
  parameter int DB_CYCLES = 4,
  localparam int ID_W     = id_w(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_din,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic             in_service
);
  irq_state_e state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d, mask_q, mask_d, rise, db, avail, clr;
  logic [ID_W-1:0] irq_id_q, irq_id_d, low_id;
  logic ack_ok;
  for (genvar g = 0; g < N_SRC; g++) begin : g_db
    irq_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .d_i    (src_in[g]),
      .db_o   (db[g]),
      .rise_o (rise[g])
    );
  end
  always_comb begin
    avail = pending_q & mask_q;
    low_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (avail[i]) low_id = ID_W'(i);
  end
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ack_ok   = 1'b0;
    case (state_q)
      IDLE: if (|avail) begin
        state_d  = REQ;
        irq_id_d = low_id;
      end
      REQ: begin
        ack_ok  = irq_ack;
        // ack beats a simultaneous mask write that disables the requesting source
        state_d = irq_ack ? SERVICE : (mask_wr && !mask_din[irq_id_q]) ? IDLE : REQ;
      end
      SERVICE: state_d = irq_done ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
    clr       = '0;
    clr[irq_id_q] = ack_ok;
    // a new debounced rise on the same bit overrides the ack clear
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_wr ? mask_din : mask_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_id_q  <= '0;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end
  assign irq        = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl with N_SRC=4, DB_CYCLES=4
module tb_irq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] src_in = '0, mask_din = '0, pending;
  logic mask_wr = 1'b0, irq_ack = 1'b0, irq_done = 1'b0;
  logic irq, in_service;
  logic [1:0] irq_id;
  int checks = 0, errors = 0;
  irq_ctrl #(.N_SRC(4), .DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_in     (src_in),
    .mask_wr    (mask_wr),
    .mask_din   (mask_din),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq        (irq),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask
  task automatic done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask
  task automatic wmask(input logic [3:0] m);
    mask_wr  = 1'b1;
    mask_din = m;
    tick();
    mask_wr  = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_irq", irq, 0);
    chk("rst_pend", pending, 0);
    chk("rst_insvc", in_service, 0);
    chk("rst_id", irq_id, 0);
    tick(2);
    rst = 1'b0;
    // latency: pending after edge 6, irq after edge 7
    src_in = 4'b0100;
    tick(5);
    chk("t1_pend_e5", pending, 0);
    tick();
    chk("t1_pend_e6", pending, 4'b0100);
    chk("t1_irq_e6", irq, 0);
    tick();
    chk("t1_irq_e7", irq, 1);
    chk("t1_id_e7", irq_id, 2);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk("t1_done_ignored", irq, 1);
    ack();
    chk("t1_insvc", in_service, 1);
    chk("t1_pend_clr", pending, 0);
    chk("t1_irq_low", irq, 0);
    src_in = 4'b0000;
    ack();
    chk("t1_ack_ignored", in_service, 1);
    done();
    chk("t1_idle", in_service, 0);
    tick(10);
    chk("t1_fall_nopend", pending, 0);
    chk("t1_fall_noirq", irq, 0);
    // 3-cycle glitch must be filtered
    src_in = 4'b0010;
    tick(3);
    src_in = 4'b0000;
    tick(10);
    chk("t2_pend", pending, 0);
    chk("t2_irq", irq, 0);
    // simultaneous sources: lowest index first
    src_in = 4'b1010;
    tick(7);
    chk("t3_irq", irq, 1);
    chk("t3_id", irq_id, 1);
    chk("t3_pend", pending, 4'b1010);
    ack();
    chk("t3_pend_ack", pending, 4'b1000);
    done();
    chk("t3_gap", irq, 0);
    tick();
    chk("t3_irq2", irq, 1);
    chk("t3_id2", irq_id, 3);
    ack();
    done();
    src_in = 4'b0000;
    tick(10);
    // mask withdrawal in REQ
    src_in = 4'b0001;
    tick(7);
    chk("t4_irq", irq, 1);
    chk("t4_id", irq_id, 0);
    wmask(4'b1110);
    chk("t4_irq_drop", irq, 0);
    chk("t4_insvc", in_service, 0);
    chk("t4_pend_kept", pending, 4'b0001);
    tick();
    chk("t4_masked", irq, 0);
    wmask(4'b1111);
    chk("t4_unmask_idle", irq, 0);
    tick();
    chk("t4_rereq", irq, 1);
    // ack wins over a same-cycle mask clear
    mask_wr  = 1'b1;
    mask_din = 4'b1110;
    irq_ack  = 1'b1;
    tick();
    mask_wr  = 1'b0;
    irq_ack  = 1'b0;
    chk("t4_ackwin_svc", in_service, 1);
    chk("t4_ackwin_pend", pending, 0);
    done();
    wmask(4'b1111);
    src_in = 4'b0000;
    tick(10);
    // new edge during service: no nesting
    src_in = 4'b0001;
    tick(7);
    ack();
    chk("t5_svc", in_service, 1);
    src_in = 4'b0101;
    tick(6);
    chk("t5_pend", pending, 4'b0100);
    chk("t5_noirq", irq, 0);
    tick(3);
    chk("t5_still_noirq", irq, 0);
    done();
    chk("t5_after_done", irq, 0);
    tick();
    chk("t5_irq", irq, 1);
    chk("t5_id", irq_id, 2);
    ack();
    done();
    src_in = 4'b0000;
    tick(10);
    // async reset mid-service
    src_in = 4'b0010;
    tick(7);
    ack();
    src_in = 4'b1010;
    tick(6);
    chk("t6_pend_pre", pending, 4'b1000);
    wmask(4'b0011);
    chk("t6_svc_pre", in_service, 1);
    src_in = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("t6_insvc", in_service, 0);
    chk("t6_pend", pending, 0);
    chk("t6_irq", irq, 0);
    chk("t6_mask", dut.mask_q, 4'b1111);
    tick(2);
    rst = 1'b0;
    tick(15);
    chk("t6_noirq", irq, 0);
    chk("t6_nopend", pending, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
